// File: rtl/cnt_updown_multi_pkg.sv
// Shared types for the multi-channel up/down counter.
//   cnt_state_e : 3-bit code for the action taken on the last clock edge
//   cnt_mode_e  : over/underflow behaviour (wrap or saturate)
//   cnt_dut_e   : tag used to label counter instances in benches
package cnt_typedef_pkg;

    localparam int CNT_STATE_W = 3;

    typedef enum logic [CNT_STATE_W-1:0] {
        INITIAL = 3'd0,
        RESET   = 3'd1,
        PREV    = 3'd2,
        LOAD    = 3'd3,
        UPCNT   = 3'd4,
        DWNCNT  = 3'd5
    } cnt_state_e;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } cnt_mode_e;

    typedef enum logic [1:0] {
        DUT_SINGLE = 2'd0,
        DUT_MULTI  = 2'd1
    } cnt_dut_e;

endpackage

// File: rtl/cnt_updown_multi_if.sv
// Control/status bundle of the multi-channel counter.
//   master : drives sat_mode, clr, load, load_val, up, dwn, flag_clr;
//            receives count, state, tc, flag
//   slave  : the counter side (directions reversed)
interface cnt_updown_multi_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 2
);
    import cnt_typedef_pkg::*;

    logic                          sat_mode;
    logic [NUM_CH-1:0]             clr;
    logic [NUM_CH-1:0]             load;
    logic [NUM_CH*WIDTH-1:0]       load_val;
    logic [NUM_CH-1:0]             up;
    logic [NUM_CH-1:0]             dwn;
    logic [NUM_CH-1:0]             flag_clr;
    logic [NUM_CH*WIDTH-1:0]       count;
    logic [NUM_CH*CNT_STATE_W-1:0] state;
    logic [NUM_CH-1:0]             tc;
    logic [NUM_CH-1:0]             flag;

    modport master (
        output sat_mode, clr, load, load_val, up, dwn, flag_clr,
        input  count, state, tc, flag
    );

    modport slave (
        input  sat_mode, clr, load, load_val, up, dwn, flag_clr,
        output count, state, tc, flag
    );
endinterface

// File: rtl/cnt_updown_multi_ch.sv
// One counter channel: clear / load / up / down with wrap or saturate,
// registered terminal-count pulse and sticky over/underflow flag.
//   clk, rst_n       : clock, async active-low reset
//   sat_mode_i       : 0 wrap, 1 saturate at the limits
//   clr_i, load_i    : sync clear to RST_VAL, sync load of load_val_i
//   up_i, dwn_i      : count requests (both high = hold)
//   flag_clr_i       : clears the sticky flag (an event in the same cycle wins)
//   count_o, state_o : registered count and last-action code
//   tc_o, flag_o     : one-cycle event pulse, sticky event flag
module cnt_updown_ch
    import cnt_typedef_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sat_mode_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             up_i,
    input  logic             dwn_i,
    input  logic             flag_clr_i,
    output logic [WIDTH-1:0] count_o,
    output cnt_state_e       state_o,
    output logic             tc_o,
    output logic             flag_o
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_V = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q, count_d;
    cnt_state_e       state_q, state_d;
    logic             tc_q, tc_d;
    logic             flag_q, flag_d;
    logic [WIDTH:0]   inc_s;   // MSB is the carry out of count + 1
    logic [WIDTH:0]   dec_s;   // MSB is the borrow out of count - 1
    logic             event_s;
    cnt_mode_e        mode_s;

    // Widened arithmetic so over/underflow comes from carry/borrow, not a compare
    always_comb begin
        inc_s  = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
        dec_s  = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
        mode_s = cnt_mode_e'(sat_mode_i);
    end

    // Next-state: priority clr > load > up-only > down-only > hold
    always_comb begin
        count_d = count_q;
        state_d = PREV;
        event_s = 1'b0;
        if (clr_i) begin
            count_d = RST_V;
            state_d = RESET;
        end else if (load_i) begin
            count_d = load_val_i;
            state_d = LOAD;
        end else if (up_i && !dwn_i) begin
            state_d = UPCNT;
            event_s = inc_s[WIDTH];
            case (mode_s)
                WRAP:     count_d = inc_s[WIDTH-1:0];
                SATURATE: count_d = inc_s[WIDTH] ? MAX_V : inc_s[WIDTH-1:0];
                default:  count_d = inc_s[WIDTH-1:0];
            endcase
        end else if (dwn_i && !up_i) begin
            state_d = DWNCNT;
            event_s = dec_s[WIDTH];
            case (mode_s)
                WRAP:     count_d = dec_s[WIDTH-1:0];
                SATURATE: count_d = dec_s[WIDTH] ? MIN_V : dec_s[WIDTH-1:0];
                default:  count_d = dec_s[WIDTH-1:0];
            endcase
        end else begin
            count_d = count_q;
            state_d = PREV;
        end
        tc_d = event_s;
        // A new event takes precedence over a flag clear in the same cycle
        if (event_s) begin
            flag_d = 1'b1;
        end else if (flag_clr_i) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_V;
            state_q <= INITIAL;
            tc_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            tc_q    <= tc_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o = count_q;
    assign state_o = state_q;
    assign tc_o    = tc_q;
    assign flag_o  = flag_q;

endmodule

// File: rtl/cnt_updown_multi.sv
// NUM_CH independent WIDTH-bit up/down/load counters sharing a wrap/saturate
// mode. Packed buses on the interface are split per channel here.
//   clk, rst_n : clock, async active-low reset
//   bus        : cnt_updown_multi_if slave modport (controls in, count/state/tc/flag out)
module cnt_updown_multi
    import cnt_typedef_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 2,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cnt_updown_multi_if.slave    bus
);

    logic [NUM_CH*WIDTH-1:0]       count_s;
    logic [NUM_CH*CNT_STATE_W-1:0] state_s;
    logic [NUM_CH-1:0]             tc_s;
    logic [NUM_CH-1:0]             flag_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cnt_state_e ch_state_s;

        cnt_updown_ch #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sat_mode_i (bus.sat_mode),
            .clr_i      (bus.clr[i]),
            .load_i     (bus.load[i]),
            .load_val_i (bus.load_val[i*WIDTH +: WIDTH]),
            .up_i       (bus.up[i]),
            .dwn_i      (bus.dwn[i]),
            .flag_clr_i (bus.flag_clr[i]),
            .count_o    (count_s[i*WIDTH +: WIDTH]),
            .state_o    (ch_state_s),
            .tc_o       (tc_s[i]),
            .flag_o     (flag_s[i])
        );

        assign state_s[i*CNT_STATE_W +: CNT_STATE_W] = ch_state_s;
    end

    assign bus.count = count_s;
    assign bus.state = state_s;
    assign bus.tc    = tc_s;
    assign bus.flag  = flag_s;

endmodule

// File: tb/tb_cnt_updown_multi.sv
module tb_cnt_updown_multi;
    import cnt_typedef_pkg::*;

    localparam int W = 8;
    localparam int N = 2;
    localparam logic [7:0] RV = 8'h00;

    typedef struct packed {
        logic [15:0] count;
        logic [5:0]  state;
        logic [1:0]  tc;
        logic [1:0]  flag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnt_updown_multi_if #(.WIDTH(W), .NUM_CH(N)) bus ();

    cnt_updown_multi #(.WIDTH(W), .NUM_CH(N), .RST_VAL(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_cnt[N];
    logic [2:0] m_st[N];
    logic       m_tc[N];
    logic       m_fl[N];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = RV;
            m_st[i]  = 3'd0;
            m_tc[i]  = 1'b0;
            m_fl[i]  = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic step(input logic sm, input logic [1:0] c, input logic [1:0] l,
                        input logic [1:0] u, input logic [1:0] d, input logic [1:0] fc,
                        input logic [15:0] lv, input string tag);
        exp_t e;
        logic ev;
        @(negedge clk);
        bus.sat_mode = sm;
        bus.clr      = c;
        bus.load     = l;
        bus.up       = u;
        bus.dwn      = d;
        bus.flag_clr = fc;
        bus.load_val = lv;
        for (int i = 0; i < N; i++) begin
            ev = 1'b0;
            if (c[i]) begin
                m_cnt[i] = RV;
                m_st[i]  = 3'd1;
            end else if (l[i]) begin
                m_cnt[i] = lv[i*8 +: 8];
                m_st[i]  = 3'd3;
            end else if (u[i] && !d[i]) begin
                m_st[i] = 3'd4;
                if (m_cnt[i] == 8'hFF) begin
                    ev       = 1'b1;
                    m_cnt[i] = sm ? 8'hFF : 8'h00;
                end else begin
                    m_cnt[i] = m_cnt[i] + 8'd1;
                end
            end else if (d[i] && !u[i]) begin
                m_st[i] = 3'd5;
                if (m_cnt[i] == 8'h00) begin
                    ev       = 1'b1;
                    m_cnt[i] = sm ? 8'h00 : 8'hFF;
                end else begin
                    m_cnt[i] = m_cnt[i] - 8'd1;
                end
            end else begin
                m_st[i] = 3'd2;
            end
            m_tc[i] = ev;
            m_fl[i] = ev | (m_fl[i] & ~fc[i]);
        end
        e.count = {m_cnt[1], m_cnt[0]};
        e.state = {m_st[1], m_st[0]};
        e.tc    = {m_tc[1], m_tc[0]};
        e.flag  = {m_fl[1], m_fl[0]};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_val({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_count"}, 32'(bus.count), 32'(e.count));
            check_val({tag, "_state"}, 32'(bus.state), 32'(e.state));
            check_val({tag, "_tc"},    32'(bus.tc),    32'(e.tc));
            check_val({tag, "_flag"},  32'(bus.flag),  32'(e.flag));
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_count"}, 32'(bus.count), 32'h0000);
        check_val({tag, "_state"}, 32'(bus.state), 32'h00);
        check_val({tag, "_tc"},    32'(bus.tc),    32'h0);
        check_val({tag, "_flag"},  32'(bus.flag),  32'h0);
    endtask

    initial begin
        bus.sat_mode = 1'b0;
        bus.clr      = 2'b00;
        bus.load     = 2'b00;
        bus.up       = 2'b00;
        bus.dwn      = 2'b00;
        bus.flag_clr = 2'b00;
        bus.load_val = 16'h0000;
        model_reset();

        // Power-on reset, held across the first edge
        @(posedge clk);
        #3;
        check_reset("por");
        #1 rst_n = 1'b1;
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, "first_idle");
        check_val("first_idle_prev", 32'(bus.state), 32'h12);

        // Channel independence: ch0 up, ch1 down from RST_VAL
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 16'h0000, "indep1");
        check_val("indep1_const", 32'(bus.count), 32'hFF01);
        check_val("indep1_tc", 32'(bus.tc), 32'h2);
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 16'h0000, "indep2");
        check_val("indep2_tc", 32'(bus.tc), 32'h0);
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 16'h0000, "indep3");
        check_val("indep3_const", 32'(bus.count), 32'hFD03);
        check_val("indep3_flag", 32'(bus.flag), 32'h2);

        // Asynchronous reset mid-count, away from any clock edge
        step(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 16'h0000, "precnt");
        #1 rst_n = 1'b0;
        #1 check_reset("midrst");
        model_reset();
        #1 rst_n = 1'b1;
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, "rst_idle");
        check_val("rst_idle_prev", 32'(bus.state), 32'h12);

        // Wrap overflow on ch0
        step(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 16'h00FE, "wrap_ld");
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 16'h0000, "wrap1");
        check_val("wrap1_cnt", 32'(bus.count[7:0]), 32'hFF);
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 16'h0000, "wrap2");
        check_val("wrap2_cnt", 32'(bus.count[7:0]), 32'h00);
        check_val("wrap2_tc", 32'(bus.tc[0]), 32'h1);
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 16'h0000, "wrap3");
        check_val("wrap3_cnt", 32'(bus.count[7:0]), 32'h01);
        check_val("wrap3_tc", 32'(bus.tc[0]), 32'h0);
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, "wrap_hold");
        check_val("wrap_sticky", 32'(bus.flag[0]), 32'h1);
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, "wrap_fclr");
        check_val("wrap_fclr_flag", 32'(bus.flag[0]), 32'h0);

        // Saturating underflow on ch1
        step(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0100, "sat_ld");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 16'h0000, "sat1");
        check_val("sat1_tc", 32'(bus.tc[1]), 32'h0);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 16'h0000, "sat2");
        check_val("sat2_tc", 32'(bus.tc[1]), 32'h1);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 16'h0000, "sat3");
        check_val("sat3_cnt", 32'(bus.count[15:8]), 32'h00);
        check_val("sat3_tc", 32'(bus.tc[1]), 32'h1);
        check_val("sat3_state", 32'(bus.state[5:3]), 32'(DWNCNT));

        // Priority clr > load > up, and up+dwn holds
        step(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 16'h0055, "prio1");
        check_val("prio1_state", 32'(bus.state[2:0]), 32'(RESET));
        step(1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 16'h0055, "prio2");
        check_val("prio2_cnt", 32'(bus.count[7:0]), 32'h55);
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 16'h0000, "prio3");
        check_val("prio3_state", 32'(bus.state[2:0]), 32'(PREV));

        // Event beats flag clear in the same cycle
        step(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 16'h00FF, "fw_ld");
        step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0000, "fw_set");
        check_val("fw_set_flag", 32'(bus.flag[0]), 32'h1);
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, "fw_clr");
        check_val("fw_clr_flag", 32'(bus.flag[0]), 32'h0);

        // Random mixed traffic, scoreboard only
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00,
                 ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
                 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 16'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
